hazard_controller: RTL
======================

# hazard_controller

Pipeline sequencing controller for the five-stage MIPS core. It watches register addresses and control bits in the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and from them drives four things:
- PC and IF/ID write enables, which produce load-use stalls.
- IF/ID and ID/EX flushes, which squash the wrong path after a taken branch, j, jal or jr resolved in EX.
- Registered forwarding selects for both ALU operands.
- Saturating stall and flush event counters for performance observation.

## Interface
Parameters:
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- id_rs  in  REG_ADDR_W  rs field (instr[25:21]) of the instruction in IF/ID.
- id_rt  in  REG_ADDR_W  rt field (instr[20:16]) of the instruction in IF/ID.
- id_uses_rt  in  1  the instruction in IF/ID reads rt as a source (R-type, sw, beq/bne).
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_reg_write  in  1  the instruction in EX writes the register file.
- ex_dest  in  REG_ADDR_W  resolved destination of the instruction in EX.
- mem_reg_write  in  1  the instruction in MEM writes the register file.
- mem_dest  in  REG_ADDR_W  destination of the instruction in MEM.
- ex_redirect  in  1  EX resolved a taken branch, j, jal or jr this cycle.
- pc_enable  out  1  PC load enable.
- if_id_enable  out  1  IF/ID load enable.
- if_id_flush  out  1  load a NOP (all zeros) into IF/ID at the next edge.
- id_ex_flush  out  1  load zeros into ID/EX at the next edge.
- fwd_a_sel  out  2  EX operand A source: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write data.
- fwd_b_sel  out  2  EX operand B source, same encoding as fwd_a_sel.
- stall_count  out  CNT_W  number of load-use bubbles inserted.
- flush_count  out  CNT_W  number of redirects taken.

## Operation
Definitions:
- hit(x, d, w) = w & (d != 0) & (d == x). Register $zero never hits.
- load_use = ex_mem_read & ex_reg_write & (hit(id_rs, ex_dest, 1) | (id_uses_rt & hit(id_rt, ex_dest, 1))).

FSM states are RUN, STALL and FLUSH (encoded 2'b00, 2'b01, 2'b10). The state records what happened in the previous cycle.

Combinational outputs:
- Redirect has priority over stall. If ex_redirect=1: if_id_flush=1, id_ex_flush=1, pc_enable=1, if_id_enable=1. The PC takes the redirect target.
- Else if load_use=1: pc_enable=0, if_id_enable=0, id_ex_flush=1, if_id_flush=0. This inserts exactly one bubble.
- Else: pc_enable=1, if_id_enable=1, both flushes 0.

Next state:
- Any state goes to FLUSH on ex_redirect.
- Otherwise it goes to STALL on load_use.
- Otherwise it goes to RUN.
- STALL never lasts two consecutive cycles for the same load: after the bubble, the load has left EX. If load_use is seen while already in STALL, that is a protocol error; it is flagged by a simulation-only assertion and the bubble is inserted anyway.

Forwarding registers are loaded at each edge and are valid while the instruction just moved into EX executes:
- If id_ex_flush=1 at that edge, fwd_a_sel and fwd_b_sel load 00.
- Otherwise, fwd_a_sel loads:
  - 01 if hit(id_rs, ex_dest, ex_reg_write);
  - else 10 if hit(id_rs, mem_dest, mem_reg_write);
  - else 00.
- fwd_b_sel uses the same rule with id_rt. It is not gated by id_uses_rt, because a spurious forward of an unused operand is harmless.
- The nearer producer (EX) wins over MEM.

Counters:
- stall_count increments on each edge where load_use & ~ex_redirect.
- flush_count increments on each edge where ex_redirect=1.
- Both saturate at 2^CNT_W-1 and never wrap.

## Timing
- Reset (reset=0, asynchronous) forces:
  - state RUN;
  - fwd_a_sel = fwd_b_sel = 00;
  - both counters 0.
- While reset is asserted, the combinational outputs evaluate normally; the surrounding pipeline registers are also held in reset.
- Reset released mid-stall: the core restarts in RUN with no pending bubble.
- Stall/flush latency is 0 cycles: outputs are valid in the same cycle as the condition and take effect at the next edge.
- Forwarding latency is 1 cycle: selects are computed in ID and registered into EX.
- Simultaneous redirect and load_use:
  - the flush wins;
  - the load_use is discarded, because its consumer is on the wrong path;
  - only flush_count increments.

## Structure
- Shared package mips_pkg holds:
  - forwarding-select constants FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10;
  - state encodings HZ_RUN, HZ_STALL, HZ_FLUSH.
- One sub-module, forward_select: purely combinational, producing the 2-bit select from (src, ex_dest, ex_reg_write, mem_dest, mem_reg_write). It is instantiated twice, for A and B.
- Counters are inline in the top module; there is no separate counter module.

## Test plan
- Reset: hold reset=0 with random inputs -> fwd selects 00, counters 0, state RUN; release reset -> pc_enable=1, if_id_enable=1.
- Load-use:
  - stimulus: ex_mem_read=1, ex_reg_write=1, ex_dest=8, id_rs=8;
  - required response: one cycle with pc_enable=0, if_id_enable=0, id_ex_flush=1;
  - stall_count goes to 1;
  - the next cycle, with ex_mem_read=0, gives pc_enable=1;
  - with id_rs=0 and ex_dest=0, no stall occurs.
- Forwarding priority:
  - id_rs=9, ex_dest=9 and mem_dest=9 with both writes set -> fwd_a_sel=01 after the edge;
  - with ex_reg_write=0 instead -> fwd_a_sel=10;
  - id_rt=3 with mem_dest=3 -> fwd_b_sel=10.
- Redirect: pulse ex_redirect=1 -> if_id_flush=1 and id_ex_flush=1 for one cycle, flush_count goes to 1, fwd selects 00 next cycle.
- Simultaneous: ex_redirect=1 together with a load_use condition -> flush only, pc_enable=1, stall_count unchanged, flush_count +1.
- Saturation: with CNT_W=4, apply 20 redirects -> flush_count=15 and held there.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_pkg                                                                 |
// | Shared constants for the five-stage MIPS core sequencing logic.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mips_pkg;

    // EX operand source selects
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Hazard controller states: what happened in the previous cycle
    localparam logic [1:0] HZ_RUN    = 2'b00;
    localparam logic [1:0] HZ_STALL  = 2'b01;
    localparam logic [1:0] HZ_FLUSH  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/forward_select.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | forward_select                                                           |
// | Picks the EX operand source for one source register; EX beats MEM.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module forward_select
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_reg_write,
    output logic [1:0]            sel
);

    logic ex_hit;
    logic mem_hit;

    // $zero is never a real producer
    assign ex_hit  = ex_reg_write  && (ex_dest  != '0) && (ex_dest  == src);
    assign mem_hit = mem_reg_write && (mem_dest != '0) && (mem_dest == src);

    always_comb begin
        sel = FWD_RF;
        if (ex_hit) begin
            sel = FWD_EXMEM;
        end else if (mem_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_controller                                                        |
// | Load-use stalls, redirect flushes, registered forwarding, event counters.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hazard_controller
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  ex_redirect,
    output logic                  pc_enable,
    output logic                  if_id_enable,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0] state;
    logic [1:0] state_next;
    logic       rs_load_hit;
    logic       rt_load_hit;
    logic       load_use;
    logic       count_stall;
    logic [1:0] fwd_a_next;
    logic [1:0] fwd_b_next;

    assign rs_load_hit = (ex_dest != '0) && (ex_dest == id_rs);
    assign rt_load_hit = id_uses_rt && (ex_dest != '0) && (ex_dest == id_rt);
    assign load_use    = ex_mem_read && ex_reg_write && (rs_load_hit || rt_load_hit);

    // A load-use under a redirect is on the wrong path and is dropped
    assign count_stall = load_use && !ex_redirect;

    always_comb begin
        pc_enable    = 1'b1;
        if_id_enable = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

    always_comb begin
        state_next = HZ_RUN;
        if (ex_redirect) begin
            state_next = HZ_FLUSH;
        end else if (load_use) begin
            state_next = HZ_STALL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HZ_RUN;
        end else begin
            state <= state_next;
        end
    end

    forward_select #(
        .REG_ADDR_W    (REG_ADDR_W)
    ) u_fwd_a (
        .src           (id_rs),
        .ex_dest       (ex_dest),
        .ex_reg_write  (ex_reg_write),
        .mem_dest      (mem_dest),
        .mem_reg_write (mem_reg_write),
        .sel           (fwd_a_next)
    );

    forward_select #(
        .REG_ADDR_W    (REG_ADDR_W)
    ) u_fwd_b (
        .src           (id_rt),
        .ex_dest       (ex_dest),
        .ex_reg_write  (ex_reg_write),
        .mem_dest      (mem_dest),
        .mem_reg_write (mem_reg_write),
        .sel           (fwd_b_next)
    );

    // A bubble entering EX must not forward anything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else if (id_ex_flush) begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else begin
            fwd_a_sel <= fwd_a_next;
            fwd_b_sel <= fwd_b_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (count_stall && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_count <= '0;
        end else if (ex_redirect && (flush_count != CNT_MAX)) begin
            flush_count <= flush_count + CNT_ONE;
        end
    end

`ifndef SYNTHESIS
    // After a bubble the load has left EX, so a second back-to-back stall is a pipeline bug
    a_no_double_stall: assert property (
        @(posedge clk) disable iff (!reset)
        !((state == HZ_STALL) && load_use)
    ) else $error("hazard_controller: load_use seen while already in STALL");
`endif

endmodule
`default_nettype wire
